// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle for seq_shift_add_multiplier.
// Signal suffixes are from the multiplier's (slave) point of view.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               valid_i;
  logic               ready_o;
  logic               signed_i;
  logic [WIDTH-1:0]   op1_i;
  logic [WIDTH-1:0]   op2_i;
  logic               valid_o;
  logic               ready_i;
  logic [2*WIDTH-1:0] product_o;

  modport slave (
    input  valid_i, signed_i, op1_i, op2_i, ready_i,
    output ready_o, valid_o, product_o
  );

  modport master (
    output valid_i, signed_i, op1_i, op2_i, ready_i,
    input  ready_o, valid_o, product_o
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 shift-add multiplier: sign-magnitude core, WIDTH iterations plus one
// cycle to apply the sign, valid/ready on both sides, registered product.
module seq_shift_add_multiplier #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  seq_shift_add_multiplier_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 valid_q;

  logic                 ready;
  logic                 accept;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic                 neg_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_d;

  always_comb begin
    ready  = ~rst_i & ((state_q == IDLE) | ((state_q == DONE) & bus.ready_i));
    accept = bus.valid_i & ready;
    // Negating the most-negative value wraps to 2^(WIDTH-1), the correct magnitude.
    mag1   = (bus.signed_i & bus.op1_i[WIDTH-1]) ? -bus.op1_i : bus.op1_i;
    mag2   = (bus.signed_i & bus.op2_i[WIDTH-1]) ? -bus.op2_i : bus.op2_i;
    neg_d  = bus.signed_i & (bus.op1_i[WIDTH-1] ^ bus.op2_i[WIDTH-1]);
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d  = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        BUSY: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            product_q <= neg_q ? -acc_q : acc_q;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Shared load path for IDLE and back-to-back DONE accepts; overrides the case above.
      if (accept) begin
        mcand_q  <= mag1;
        mplier_q <= mag2;
        neg_q    <= neg_d;
        acc_q    <= '0;
        cnt_q    <= '0;
        state_q  <= BUSY;
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.product_o = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomized checks of seq_shift_add_multiplier at WIDTH 8, 16 and 2.
module tb_seq_shift_add_multiplier;

  localparam int unsigned N16 = 1200;

  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst16 = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.WIDTH(8))  b8 ();
  seq_shift_add_multiplier_if #(.WIDTH(16)) b16 ();
  seq_shift_add_multiplier_if #(.WIDTH(2))  b2 ();

  seq_shift_add_multiplier #(.WIDTH(8))  u8  (.clk_i(clk), .rst_i(rst8),  .bus(b8));
  seq_shift_add_multiplier #(.WIDTH(16)) u16 (.clk_i(clk), .rst_i(rst16), .bus(b16));
  seq_shift_add_multiplier #(.WIDTH(2))  u2  (.clk_i(clk), .rst_i(rst2),  .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer multiply of the operands as interpreted by mode, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input bit s);
    longint av, bv, p;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    av = longint'(a & m);
    bv = longint'(b & m);
    if (s && a[w-1]) av = av - longint'(64'd1 << w);
    if (s && b[w-1]) bv = bv - longint'(64'd1 << w);
    p = av * bv;
    return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  // Called just after the accepting edge; counts edges until valid_o rises.
  task automatic wait8(output int n, output bit rdy_low);
    n = 0;
    rdy_low = 1'b1;
    while (!b8.valid_o && n < 40) begin
      if (b8.ready_o) rdy_low = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int n;
    bit rl;
    b8.signed_i = s; b8.op1_i = a; b8.op2_i = b; b8.valid_i = 1'b1;
    #1;
    chk({tag, " ready_o before accept"}, 64'(b8.ready_o), 64'd1);
    @(posedge clk); #1;
    b8.valid_i = 1'b0;
    wait8(n, rl);
    chk({tag, " latency"}, 64'(n), 64'd9);
    chk({tag, " ready_o low while busy"}, 64'(rl), 64'd1);
    chk({tag, " product"}, 64'(b8.product_o), 64'(exp));
    chk({tag, " model agrees"}, ref_mul(8, 64'(a), 64'(b), s), 64'(exp));
  endtask

  task automatic take8(input logic [15:0] exp, input string tag);
    b8.ready_i = 1'b1;
    @(posedge clk); #1;
    b8.ready_i = 1'b0;
    chk({tag, " valid_o drops on handoff"}, 64'(b8.valid_o), 64'd0);
    chk({tag, " product held after handoff"}, 64'(b8.product_o), 64'(exp));
  endtask

  task automatic op2w(input bit s, input logic [1:0] a, input logic [1:0] b,
                      input logic [3:0] exp, input string tag);
    int n;
    b2.signed_i = s; b2.op1_i = a; b2.op2_i = b; b2.valid_i = 1'b1;
    #1;
    chk({tag, " ready_o"}, 64'(b2.ready_o), 64'd1);
    @(posedge clk); #1;
    b2.valid_i = 1'b0;
    n = 0;
    while (!b2.valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd3);
    chk({tag, " product"}, 64'(b2.product_o), 64'(exp));
    b2.ready_i = 1'b1;
    @(posedge clk); #1;
    b2.ready_i = 1'b0;
    chk({tag, " valid_o drops"}, 64'(b2.valid_o), 64'd0);
  endtask

  initial begin
    int n;
    bit rl;
    bit stable;
    bit spurious;
    int accepts;
    int results;
    int cyc;
    logic [31:0] q[$];
    logic [31:0] e;

    b8.valid_i = 1'b0; b8.ready_i = 1'b0; b8.signed_i = 1'b0; b8.op1_i = '0; b8.op2_i = '0;
    b16.valid_i = 1'b0; b16.ready_i = 1'b0; b16.signed_i = 1'b0; b16.op1_i = '0; b16.op2_i = '0;
    b2.valid_i = 1'b0; b2.ready_i = 1'b0; b2.signed_i = 1'b0; b2.op1_i = '0; b2.op2_i = '0;

    // Reset state, including ready_o forced low with valid_i asserted.
    b8.valid_i = 1'b1;
    #1;
    chk("reset ready_o", 64'(b8.ready_o), 64'd0);
    chk("reset valid_o", 64'(b8.valid_o), 64'd0);
    chk("reset product_o", 64'(b8.product_o), 64'd0);
    @(posedge clk); #1;
    chk("reset no accept", 64'(b8.valid_o), 64'd0);
    b8.valid_i = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b0; rst16 = 1'b0; rst2 = 1'b0;
    #1;
    chk("idle ready_o", 64'(b8.ready_o), 64'd1);

    op8(1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
    take8(16'hFE01, "u255x255");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s-128x-128");
    take8(16'h4000, "s-128x-128");
    op8(1'b1, 8'hFF, 8'h01, 16'hFFFF, "s-1x1");
    take8(16'hFFFF, "s-1x1");
    op8(1'b0, 8'd0, 8'd200, 16'h0000, "u0x200");
    take8(16'h0000, "u0x200");

    // Backpressure in DONE with new operands offered and ignored.
    op8(1'b1, 8'd127, 8'h80, 16'hC080, "s127x-128");
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b8.valid_i = 1'b1; b8.op1_i = 8'($urandom); b8.op2_i = 8'($urandom);
      #1;
      if (b8.ready_o !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      if (b8.valid_o !== 1'b1 || b8.product_o !== 16'hC080) stable = 1'b0;
    end
    chk("backpressure stable", 64'(stable), 64'd1);
    b8.ready_i = 1'b1; b8.valid_i = 1'b1; b8.signed_i = 1'b0; b8.op1_i = 8'd7; b8.op2_i = 8'd6;
    #1;
    chk("b2b ready_o", 64'(b8.ready_o), 64'd1);
    @(posedge clk); #1;
    b8.ready_i = 1'b0; b8.valid_i = 1'b0;
    chk("b2b valid_o dropped", 64'(b8.valid_o), 64'd0);
    wait8(n, rl);
    chk("b2b latency", 64'(n), 64'd9);
    chk("b2b product", 64'(b8.product_o), 64'h002A);
    take8(16'h002A, "b2b");

    // Reset during BUSY discards the in-flight result.
    b8.signed_i = 1'b0; b8.op1_i = 8'd100; b8.op2_i = 8'd100; b8.valid_i = 1'b1;
    @(posedge clk); #1;
    b8.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    chk("midbusy rst product_o", 64'(b8.product_o), 64'd0);
    chk("midbusy rst valid_o", 64'(b8.valid_o), 64'd0);
    chk("midbusy rst ready_o", 64'(b8.ready_o), 64'd0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (b8.valid_o !== 1'b0) spurious = 1'b1;
    end
    chk("no valid after reset", 64'(spurious), 64'd0);
    op8(1'b0, 8'd3, 8'd5, 16'h000F, "u3x5 after reset");
    take8(16'h000F, "u3x5 after reset");

    // WIDTH=2 corners.
    op2w(1'b1, 2'b10, 2'b10, 4'h4, "w2 s-2x-2");
    op2w(1'b0, 2'b11, 2'b11, 4'h9, "w2 u3x3");

    // WIDTH=16 random traffic against a queue of model results.
    accepts = 0; results = 0; cyc = 0;
    while ((accepts < int'(N16) || q.size() > 0) && cyc < 60000) begin
      b16.ready_i = (accepts >= int'(N16)) ? 1'b1 : 1'($urandom_range(0, 1));
      if (accepts < int'(N16)) begin
        b16.valid_i  = ($urandom_range(0, 3) != 0);
        b16.signed_i = 1'($urandom_range(0, 1));
        b16.op1_i    = 16'($urandom);
        b16.op2_i    = 16'($urandom);
      end else begin
        b16.valid_i = 1'b0;
      end
      #1;
      if (b16.valid_o && b16.ready_i) begin
        if (q.size() == 0) begin
          chk("w16 result without accept", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("w16 product", 64'(b16.product_o), 64'(e));
        end
        results++;
      end
      if (b16.valid_i && b16.ready_o) begin
        q.push_back(32'(ref_mul(16, 64'(b16.op1_i), 64'(b16.op2_i), b16.signed_i)));
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b16.valid_i = 1'b0;
    chk("w16 all accepted", 64'(accepts), 64'(N16));
    chk("w16 results equal accepts", 64'(results), 64'(accepts));
    chk("w16 queue drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
